// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word over req/ack, holds it for downstream.
// Latency: 1 cycle BOOT after reset, then >=1 cycle FETCH (until ack) + >=1 cycle HOLD (until advance).
// Backpressure: imem_ack=0 stalls in FETCH with req/addr stable; advance=0 stalls in HOLD with Instr/PC stable.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   imem_req/addr/rdata/ack  instruction memory handshake (addr always equals PC)
//   Instr, InstrValid, PC    held instruction, its valid flag and its address
//   PCPlus8                  PC + 8 (architectural PC read value), combinational from PC
//   advance, PCSrc, Result   downstream accept, branch select and branch target
//   retired                  count of accepted instructions (wraps)

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    input  logic        advance,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        imem_req   = 1'b0;
        InstrValid = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                InstrValid = 1'b1;
                if (advance) begin
                    // Branch targets are forced word-aligned; misaligned low bits are dropped silently.
                    pc_d      = PCSrc ? (Result & 32'hFFFF_FFFC) : (pc_q + 32'd4);
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign PCPlus8   = pc_q + 32'd8;
    assign Instr     = instr_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized traffic,
// compared every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        advance = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] Result = 32'h0;
    logic [31:0] retired;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus8    (PCPlus8),
        .advance    (advance),
        .PCSrc      (PCSrc),
        .Result     (Result),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: where the fetch stage is in its instruction's life.
    bit          m_started;   // at least one edge seen since reset released
    bit          m_holding;   // an instruction has been delivered and not yet accepted
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;

    task automatic model_reset();
        m_started = 1'b0;
        m_holding = 1'b0;
        m_pc      = RST_PC;
        m_instr   = 32'h0;
        m_retired = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req",   {31'd0, imem_req},   {31'd0, m_started && !m_holding});
        chk("InstrValid", {31'd0, InstrValid}, {31'd0, m_holding});
        chk("imem_addr",  imem_addr, m_pc);
        chk("PC",         PC,        m_pc);
        chk("PCPlus8",    PCPlus8,   m_pc + 32'd8);
        chk("Instr",      Instr,     m_instr);
        chk("retired",    retired,   m_retired);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check off-edge.
    task automatic step(input bit ack, input logic [31:0] rd, input bit adv,
                        input bit src, input logic [31:0] res);
        bit          n_started = m_started;
        bit          n_holding = m_holding;
        logic [31:0] n_pc      = m_pc;
        logic [31:0] n_instr   = m_instr;
        logic [31:0] n_retired = m_retired;
        imem_ack   = ack;
        imem_rdata = rd;
        advance    = adv;
        PCSrc      = src;
        Result     = res;
        if (!m_started) begin
            n_started = 1'b1;
        end else if (!m_holding && ack) begin
            n_instr   = rd;
            n_holding = 1'b1;
        end else if (m_holding && adv) begin
            n_pc      = src ? {res[31:2], 2'b00} : m_pc + 32'd4;
            n_retired = m_retired + 32'd1;
            n_holding = 1'b0;
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            m_started = n_started;
            m_holding = n_holding;
            m_pc      = n_pc;
            m_instr   = n_instr;
            m_retired = n_retired;
        end
        check_all();
    endtask

    // Assert reset between edges with junk on the inputs, then release it mid-cycle.
    task automatic async_reset();
        #3;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBADC_0DE5;
        advance    = 1'b1;
        reset      = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] saved;
        model_reset();

        // Reset values before any clock edge, then across one edge still in reset.
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Back-to-back traffic: BOOT edge, then 6 instructions at 2 cycles each.
        for (int i = 0; i < 13; i++) step(1'b1, $urandom, 1'b1, 1'b0, 32'h0);
        chk("burst_retired", retired, 32'd6);
        chk("burst_addr", imem_addr, 32'd24);

        // Slow memory: req/addr stable across three idle cycles, then ack.
        for (int i = 0; i < 3; i++) step(1'b0, $urandom, 1'b1, 1'b1, $urandom);
        step(1'b1, 32'hE3A0_1005, 1'b0, 1'b0, 32'h0);
        chk("slow_instr", Instr, 32'hE3A0_1005);

        // Downstream stall for 5 cycles with stray acks, then a misaligned branch.
        saved = retired;
        for (int i = 0; i < 5; i++) step(i[0], $urandom, 1'b0, 1'b1, $urandom);
        chk("stall_instr", Instr, 32'hE3A0_1005);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
        chk("branch_addr", imem_addr, 32'h0000_0100);
        chk("branch_retired", retired, saved + 32'd1);

        // Advance pulsed in FETCH is ignored; then branch to top of memory and wrap.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0444);
        chk("fetch_adv_ignored", PC, 32'h0000_0100);
        step(1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        chk("top_pcplus8", PCPlus8, 32'h0000_0004);
        step(1'b1, 32'h3333_4444, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset mid-FETCH, then a late ack while in BOOT.
        async_reset();
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        chk("boot_ack_instr", Instr, 32'h0000_0000);

        // Reach HOLD and reset there.
        step(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
        async_reset();
        chk("hold_rst_valid", {31'd0, InstrValid}, 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | $urandom_range(0, 7)) : $urandom;
            if ($urandom_range(0, 99) == 0) async_reset();
            step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) != 0, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
